piarb_pbuf_read_resp: RTL
=========================

Name: piarb_pbuf_read_resp

Overview:
Responder end of the PI arbiter packet-buffer read interface. It serves buffer-chain requests (buf_req) by returning the next-buffer pointer from a link RAM, and frame-data requests (data_req) by returning buffer contents from a data RAM, tagged with sop/eop/inst and port ids. It sits between the packet buffer memories and the piarb read-data initiator. It also owns the link/data RAM write ports used by the buffer manager.

Parameters:
BPTR_NBITS, 8, buffer pointer width; RAM depth is 1<<BPTR_NBITS
ID_NBITS, 4, port id width
DATA_NBITS, 64, data word width per buffer

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
buf_req  in  1  next-pointer lookup request, one per cycle
buf_req_ptr  in  BPTR_NBITS  buffer whose successor is requested
buf_ack_valid  out  1  lookup response valid
buf_ack_ptr  out  BPTR_NBITS  next buffer pointer
data_req  in  1  data read request
data_req_src_port_id  in  ID_NBITS  source port tag
data_req_dst_port_id  in  ID_NBITS  destination port tag
data_req_sop  in  1  first buffer of packet
data_req_eop  in  1  last buffer of packet
data_req_buf_ptr  in  BPTR_NBITS  buffer to read
data_req_inst  in  1  buffer carries instruction words
data_ack_valid  out  1  data response valid
data_ack_sop  out  1  echoed sop
data_ack_eop  out  1  echoed eop
data_ack_inst  out  1  echoed inst
data_ack_src_port_id  out  ID_NBITS  echoed source port
data_ack_dst_port_id  out  ID_NBITS  echoed destination port
data_ack_data  out  DATA_NBITS  buffer contents
link_wr  in  1  link RAM write
link_wr_ptr  in  BPTR_NBITS  link RAM address
link_wr_next  in  BPTR_NBITS  next pointer to store
data_wr  in  1  data RAM write
data_wr_ptr  in  BPTR_NBITS  data RAM address
data_wr_data  in  DATA_NBITS  data to store
proto_err  out  1  sticky protocol error
pkt_cnt  out  16  packets completed (eop acks issued)

Behaviour:
- Reset (rstn low at clk edge): buf_ack_valid, data_ack_valid, proto_err = 0; pkt_cnt = 0; framing FSM = IDLE; pipeline valids cleared. Data-type outputs (ptrs, data, tags) not reset. RAM contents not reset.
- Reset mid-operation: in-flight requests are dropped; no ack emitted for any request accepted before reset.
- No backpressure: every request accepted; no ready signal.
- buf path latency exactly 2 cycles: buf_req at cycle N -> buf_ack_valid at N+2. Stage 1 registers address/valid; stage 2 registers RAM output.
- data path latency exactly 2 cycles, same staging; sop/eop/inst/port tags pipelined alongside and emitted in the same cycle as data_ack_data.
- Read-during-write, same address, same cycle: the read returns the newly written value (write-first bypass). Write at N, read same address at N+1: new value.
- buf and data paths are independent; simultaneous buf_req and data_req are both served, each at its 2-cycle latency.
- Framing FSM, advanced on data_req:
  - IDLE: sop&eop -> IDLE, pkt complete; sop&~eop -> IN_PKT; ~sop -> proto_err, stay IDLE.
  - IN_PKT: ~sop&eop -> IDLE, pkt complete; ~sop&~eop -> IN_PKT; sop -> proto_err, restart packet (IN_PKT, or IDLE if eop).
  - Requests are still served on error; acks echo inputs unchanged.
- proto_err is sticky until reset.
- pkt_cnt increments on the cycle data_ack_valid&data_ack_eop is driven; wraps 0xFFFF -> 0.

Optional Feature:
PIARB_PBUF_PARITY_EN: when defined, the data RAM stores one even-parity bit per word, computed on write and checked at stage 2 of the read. A mismatch asserts the extra output data_ack_par_err (1 bit) coincident with data_ack_valid and sets proto_err. When undefined, the port and the parity storage are absent and behaviour is otherwise identical.

Test Plan:
- link_wr ptr 5 next 9; buf_req ptr 5 at cycle 10 -> buf_ack_valid at 12 with buf_ack_ptr 9; no other ack cycles.
- data_wr ptr 3 = 0xA5A5; data_req ptr 3, sop=1, eop=1, src 2, dst 7 -> 2 cycles later data_ack with data 0xA5A5, sop=1, eop=1, src 2, dst 7; pkt_cnt = 1; proto_err = 0.
- 3-buffer packet, back-to-back requests (sop; mid; eop) -> 3 consecutive acks with sop 1,0,0 and eop 0,0,1; pkt_cnt +1.
- link_wr ptr 4 = 11 and buf_req ptr 4 in the same cycle, old value 6 -> ack returns 11.
- data_req sop while IN_PKT -> proto_err = 1 and held; ack still issued.
- With the parity macro defined: force a RAM parity-bit flip, then read -> data_ack_par_err = 1 and proto_err = 1. Assert rstn low mid-packet -> no acks, outputs cleared.

Source files
------------

// File: rtl/piarb_pbuf_read_resp.sv
// Packet-buffer read responder: link RAM next-pointer lookups and data RAM reads, 2-cycle latency.
// Optional PIARB_PBUF_PARITY_EN adds a per-word even-parity bit and the data_ack_par_err output.
module piarb_pbuf_read_resp #(
    parameter int BPTR_NBITS = 8,
    parameter int ID_NBITS   = 4,
    parameter int DATA_NBITS = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  buf_req,
    input  logic [BPTR_NBITS-1:0] buf_req_ptr,
    output logic                  buf_ack_valid,
    output logic [BPTR_NBITS-1:0] buf_ack_ptr,
    input  logic                  data_req,
    input  logic [ID_NBITS-1:0]   data_req_src_port_id,
    input  logic [ID_NBITS-1:0]   data_req_dst_port_id,
    input  logic                  data_req_sop,
    input  logic                  data_req_eop,
    input  logic [BPTR_NBITS-1:0] data_req_buf_ptr,
    input  logic                  data_req_inst,
    output logic                  data_ack_valid,
    output logic                  data_ack_sop,
    output logic                  data_ack_eop,
    output logic                  data_ack_inst,
    output logic [ID_NBITS-1:0]   data_ack_src_port_id,
    output logic [ID_NBITS-1:0]   data_ack_dst_port_id,
    output logic [DATA_NBITS-1:0] data_ack_data,
    input  logic                  link_wr,
    input  logic [BPTR_NBITS-1:0] link_wr_ptr,
    input  logic [BPTR_NBITS-1:0] link_wr_next,
    input  logic                  data_wr,
    input  logic [BPTR_NBITS-1:0] data_wr_ptr,
    input  logic [DATA_NBITS-1:0] data_wr_data,
    output logic                  proto_err,
    output logic [15:0]           pkt_cnt
`ifdef PIARB_PBUF_PARITY_EN
    ,
    output logic                  data_ack_par_err
`endif
);
    localparam int DEPTH = 1 << BPTR_NBITS;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    typedef struct packed {
        logic                sop;
        logic                eop;
        logic                inst;
        logic [ID_NBITS-1:0] src;
        logic [ID_NBITS-1:0] dst;
    } tag_t;

    logic [BPTR_NBITS-1:0] link_ram [DEPTH];
    logic [DATA_NBITS-1:0] data_ram [DEPTH];

    logic                  buf_vld_s1, data_vld_s1;
    logic [BPTR_NBITS-1:0] buf_ptr_s1, data_ptr_s1;
    tag_t                  tag_s1;
    logic [0:0]            state, state_nxt;
    logic                  frame_err;
    logic                  par_err;

    // Reads sample the RAM one cycle after the request, so a write in the
    // request cycle is already committed: write-first without a bypass mux.
    always_ff @(posedge clk) begin
        if (link_wr) link_ram[link_wr_ptr] <= link_wr_next;
        if (data_wr) data_ram[data_wr_ptr] <= data_wr_data;
    end

`ifdef PIARB_PBUF_PARITY_EN
    logic par_ram [DEPTH];
    always_ff @(posedge clk) begin
        if (data_wr) par_ram[data_wr_ptr] <= ^data_wr_data;
    end
    assign par_err = data_vld_s1 & ((^data_ram[data_ptr_s1]) != par_ram[data_ptr_s1]);
`else
    assign par_err = 1'b0;
`endif

    // Framing check; a stray sop restarts the packet, a stray middle/eop is ignored.
    always_comb begin
        state_nxt = state;
        frame_err = 1'b0;
        if (data_req) begin
            case (state)
                ST_IDLE: begin
                    frame_err = ~data_req_sop;
                    if (data_req_sop && !data_req_eop) state_nxt = ST_IN_PKT;
                end
                default: begin
                    frame_err = data_req_sop;
                    if (data_req_eop) state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            buf_vld_s1     <= 1'b0;
            data_vld_s1    <= 1'b0;
            buf_ack_valid  <= 1'b0;
            data_ack_valid <= 1'b0;
            state          <= ST_IDLE;
            proto_err      <= 1'b0;
            pkt_cnt        <= 16'd0;
        end else begin
            buf_vld_s1     <= buf_req;
            data_vld_s1    <= data_req;
            buf_ack_valid  <= buf_vld_s1;
            data_ack_valid <= data_vld_s1;
            state          <= state_nxt;
            proto_err      <= proto_err | frame_err | par_err;
            pkt_cnt        <= pkt_cnt + 16'(data_vld_s1 & tag_s1.eop);
        end
    end

`ifdef PIARB_PBUF_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) data_ack_par_err <= 1'b0;
        else       data_ack_par_err <= par_err;
    end
`endif

    // Payload registers carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        buf_ptr_s1           <= buf_req_ptr;
        data_ptr_s1          <= data_req_buf_ptr;
        tag_s1               <= '{sop: data_req_sop, eop: data_req_eop, inst: data_req_inst,
                                  src: data_req_src_port_id, dst: data_req_dst_port_id};
        buf_ack_ptr          <= link_ram[buf_ptr_s1];
        data_ack_data        <= data_ram[data_ptr_s1];
        data_ack_sop         <= tag_s1.sop;
        data_ack_eop         <= tag_s1.eop;
        data_ack_inst        <= tag_s1.inst;
        data_ack_src_port_id <= tag_s1.src;
        data_ack_dst_port_id <= tag_s1.dst;
    end

endmodule
